// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port BRAM between two writers
// and two readers; read data returns to the requester with a tagged strobe.
module bram_rr_arbiter #(
   parameter  int N_ADDR     = 256,
   parameter  int DATA_WIDTH = 16,
   parameter  int RD_LATENCY = 1,
   localparam int AW         = $clog2(N_ADDR)
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  wr0_valid,
   output logic                  wr0_ready,
   input  logic [AW-1:0]         wr0_addr,
   input  logic [DATA_WIDTH-1:0] wr0_data,

   input  logic                  wr1_valid,
   output logic                  wr1_ready,
   input  logic [AW-1:0]         wr1_addr,
   input  logic [DATA_WIDTH-1:0] wr1_data,

   input  logic                  rd0_valid,
   output logic                  rd0_ready,
   input  logic [AW-1:0]         rd0_addr,
   output logic [DATA_WIDTH-1:0] rd0_dout,
   output logic                  rd0_dvalid,

   input  logic                  rd1_valid,
   output logic                  rd1_ready,
   input  logic [AW-1:0]         rd1_addr,
   output logic [DATA_WIDTH-1:0] rd1_dout,
   output logic                  rd1_dvalid,

   output logic                  bram_wen,
   output logic [AW-1:0]         bram_wadd,
   output logic [DATA_WIDTH-1:0] bram_win,
   output logic                  bram_ren,
   output logic [AW-1:0]         bram_radd,
   input  logic [DATA_WIDTH-1:0] bram_wout
);

   typedef enum logic {
      CL0 = 1'b0,
      CL1 = 1'b1
   } client_e;

   client_e wr_ptr;
   client_e rd_ptr;

   logic wr_gnt0, wr_gnt1;
   logic rd_gnt0, rd_gnt1;

   // Tag stage 0 lines up with bram_ren; stage RD_LATENCY with bram_wout.
   logic [RD_LATENCY:0] tag_vld;
   logic [RD_LATENCY:0] tag_id;

   logic                  ret_vld, ret0, ret1;
   logic [DATA_WIDTH-1:0] dout0_q, dout1_q;

   // ---------------------------------------------------------------- grants
   always_comb begin
      wr_gnt0 = ~rst & wr0_valid & (~wr1_valid | (wr_ptr == CL0));
      wr_gnt1 = ~rst & wr1_valid & (~wr0_valid | (wr_ptr == CL1));
      rd_gnt0 = ~rst & rd0_valid & (~rd1_valid | (rd_ptr == CL0));
      rd_gnt1 = ~rst & rd1_valid & (~rd0_valid | (rd_ptr == CL1));
   end

   assign wr0_ready = wr_gnt0;
   assign wr1_ready = wr_gnt1;
   assign rd0_ready = rd_gnt0;
   assign rd1_ready = rd_gnt1;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= CL0;
         rd_ptr <= CL0;
      end else begin
         if (wr_gnt0)
            wr_ptr <= CL1;
         else if (wr_gnt1)
            wr_ptr <= CL0;

         if (rd_gnt0)
            rd_ptr <= CL1;
         else if (rd_gnt1)
            rd_ptr <= CL0;
      end
   end

   // ------------------------------------------------------------ write path
   always_ff @(posedge clk) begin
      if (rst) begin
         bram_wen  <= 1'b0;
         bram_wadd <= '0;
         bram_win  <= '0;
      end else begin
         bram_wen <= wr_gnt0 | wr_gnt1;
         if (wr_gnt0) begin
            bram_wadd <= wr0_addr;
            bram_win  <= wr0_data;
         end else if (wr_gnt1) begin
            bram_wadd <= wr1_addr;
            bram_win  <= wr1_data;
         end
      end
   end

   // ------------------------------------------------------------- read path
   always_ff @(posedge clk) begin
      if (rst) begin
         bram_radd <= '0;
         tag_vld   <= '0;
         tag_id    <= '0;
      end else begin
         if (rd_gnt0)
            bram_radd <= rd0_addr;
         else if (rd_gnt1)
            bram_radd <= rd1_addr;
         tag_vld <= {tag_vld[RD_LATENCY-1:0], rd_gnt0 | rd_gnt1};
         tag_id  <= {tag_id[RD_LATENCY-1:0], rd_gnt1};
      end
   end

   assign bram_ren = tag_vld[0];

   // Returned data arrives combinationally from the BRAM on the strobe cycle;
   // the holding registers keep it visible until the next strobe.
   always_comb begin
      ret_vld = tag_vld[RD_LATENCY] & ~rst;
      ret0    = ret_vld & ~tag_id[RD_LATENCY];
      ret1    = ret_vld &  tag_id[RD_LATENCY];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout0_q <= '0;
         dout1_q <= '0;
      end else begin
         if (ret0)
            dout0_q <= bram_wout;
         if (ret1)
            dout1_q <= bram_wout;
      end
   end

   always_comb begin
      rd0_dvalid = ret0;
      rd1_dvalid = ret1;
      rd0_dout   = '0;
      rd1_dout   = '0;
      if (!rst) begin
         rd0_dout = ret0 ? bram_wout : dout0_q;
         rd1_dout = ret1 ? bram_wout : dout1_q;
      end
   end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a read-first BRAM model (RD_LATENCY = 1).
module tb_bram_rr_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr0_valid = 1'b0, wr1_valid = 1'b0;
   logic          wr0_ready, wr1_ready;
   logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
   logic [DW-1:0] wr0_data = '0, wr1_data = '0;
   logic          rd0_valid = 1'b0, rd1_valid = 1'b0;
   logic          rd0_ready, rd1_ready;
   logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
   logic [DW-1:0] rd0_dout, rd1_dout;
   logic          rd0_dvalid, rd1_dvalid;
   logic          bram_wen, bram_ren;
   logic [AW-1:0] bram_wadd, bram_radd;
   logic [DW-1:0] bram_win;
   logic [DW-1:0] bram_wout = '0;

   logic [DW-1:0] mem [0:255];

   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   always #5 clk = ~clk;

   bram_rr_arbiter #(.N_ADDR(256), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
      .rd0_dout(rd0_dout), .rd0_dvalid(rd0_dvalid),
      .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
      .rd1_dout(rd1_dout), .rd1_dvalid(rd1_dvalid),
      .bram_wen(bram_wen), .bram_wadd(bram_wadd), .bram_win(bram_win),
      .bram_ren(bram_ren), .bram_radd(bram_radd), .bram_wout(bram_wout)
   );

   // Read-first simple-dual-port BRAM, one cycle read latency
   always @(posedge clk) begin
      if (bram_ren) bram_wout <= mem[bram_radd];
      if (bram_wen) mem[bram_wadd] <= bram_win;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".wen"},  {31'd0, bram_wen},   32'd0);
      check({tag, ".ren"},  {31'd0, bram_ren},   32'd0);
      check({tag, ".wadd"}, {24'd0, bram_wadd},  32'd0);
      check({tag, ".radd"}, {24'd0, bram_radd},  32'd0);
      check({tag, ".win"},  {16'd0, bram_win},   32'd0);
      check({tag, ".d0"},   {16'd0, rd0_dout},   32'd0);
      check({tag, ".d1"},   {16'd0, rd1_dout},   32'd0);
      check({tag, ".dv0"},  {31'd0, rd0_dvalid}, 32'd0);
      check({tag, ".dv1"},  {31'd0, rd1_dvalid}, 32'd0);
      check({tag, ".rdy"},  {28'd0, wr0_ready, wr1_ready, rd0_ready, rd1_ready}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n0, n1, j;
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      mem[7] = 16'h00FF;
      mem[3] = 16'h1111;
      for (int a = 20; a < 26; a++) mem[a] = 16'hA000 + 16'(a);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // Single writer
      wr0_valid = 1'b1; wr0_addr = 8'd5; wr0_data = 16'h1234;
      #1;
      check("w1.rdy0", {31'd0, wr0_ready}, 32'd1);
      check("w1.rdy1", {31'd0, wr1_ready}, 32'd0);
      step();
      wr0_valid = 1'b0;
      check("w1.wen",  {31'd0, bram_wen}, 32'd1);
      check("w1.wadd", {24'd0, bram_wadd}, 32'd5);
      check("w1.win",  {16'd0, bram_win}, 32'h1234);
      step();
      check("w1.wen_off",  {31'd0, bram_wen}, 32'd0);
      check("w1.wadd_hold", {24'd0, bram_wadd}, 32'd5);

      // Two writers contending; reset puts the pointer back on writer 0
      do_reset();
      wr0_addr = 8'd1; wr0_data = 16'h000A;
      wr1_addr = 8'd2; wr1_data = 16'h000B;
      for (int i = 0; i < 4; i++) begin
         wr0_valid = 1'b1; wr1_valid = 1'b1;
         #1;
         check($sformatf("w2.rdy0_%0d", i), {31'd0, wr0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("w2.rdy1_%0d", i), {31'd0, wr1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
         step();
         check($sformatf("w2.wen_%0d", i),  {31'd0, bram_wen}, 32'd1);
         check($sformatf("w2.wadd_%0d", i), {24'd0, bram_wadd}, (i % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("w2.win_%0d", i),  {16'd0, bram_win}, (i % 2 == 0) ? 32'hA : 32'hB);
      end
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      step();
      check("w2.wen_off", {31'd0, bram_wen}, 32'd0);

      // Single read by reader 1
      rd1_valid = 1'b1; rd1_addr = 8'd7;
      #1;
      check("r1.rdy1", {31'd0, rd1_ready}, 32'd1);
      check("r1.rdy0", {31'd0, rd0_ready}, 32'd0);
      step();
      rd1_valid = 1'b0;
      check("r1.ren",  {31'd0, bram_ren}, 32'd1);
      check("r1.radd", {24'd0, bram_radd}, 32'd7);
      check("r1.dv1_early", {31'd0, rd1_dvalid}, 32'd0);
      step();
      check("r1.dv1",  {31'd0, rd1_dvalid}, 32'd1);
      check("r1.d1",   {16'd0, rd1_dout}, 32'h00FF);
      check("r1.dv0",  {31'd0, rd0_dvalid}, 32'd0);
      step();
      check("r1.dv1_off", {31'd0, rd1_dvalid}, 32'd0);
      check("r1.d1_hold", {16'd0, rd1_dout}, 32'h00FF);

      // Both readers continuously: grants alternate from reader 0, handshake j
      // reads address 20+j and pulses two cycles later on reader j%2
      n0 = 0; n1 = 0;
      for (int c = 0; c < 8; c++) begin
         if (c < 6) begin
            rd0_valid = 1'b1; rd0_addr = 8'(20 + 2 * n0);
            rd1_valid = 1'b1; rd1_addr = 8'(21 + 2 * n1);
            #1;
            check($sformatf("r2.rdy0_%0d", c), {31'd0, rd0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("r2.rdy1_%0d", c), {31'd0, rd1_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
         end else begin
            rd0_valid = 1'b0; rd1_valid = 1'b0;
         end
         step();
         if (c < 6) begin
            if (c % 2 == 0) n0++; else n1++;
         end
         if (c >= 1 && c <= 6) begin
            j = c - 1;
            check($sformatf("r2.dv0_%0d", j), {31'd0, rd0_dvalid}, (j % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("r2.dv1_%0d", j), {31'd0, rd1_dvalid}, (j % 2 == 1) ? 32'd1 : 32'd0);
            if (j % 2 == 0)
               check($sformatf("r2.d0_%0d", j), {16'd0, rd0_dout}, 32'hA000 + 32'd20 + j);
            else
               check($sformatf("r2.d1_%0d", j), {16'd0, rd1_dout}, 32'hA000 + 32'd20 + j);
         end else begin
            check($sformatf("r2.dv_idle_%0d", c), {30'd0, rd0_dvalid, rd1_dvalid}, 32'd0);
         end
      end
      rd0_valid = 1'b0; rd1_valid = 1'b0;

      // Same-cycle write and read of one address returns the old word
      wr0_valid = 1'b1; wr0_addr = 8'd3; wr0_data = 16'h5555;
      rd0_valid = 1'b1; rd0_addr = 8'd3;
      #1;
      check("rw.rdy", {30'd0, wr0_ready, rd0_ready}, 32'd3);
      step();
      wr0_valid = 1'b0; rd0_valid = 1'b0;
      check("rw.en", {30'd0, bram_wen, bram_ren}, 32'd3);
      step();
      check("rw.dv0", {31'd0, rd0_dvalid}, 32'd1);
      check("rw.old", {16'd0, rd0_dout}, 32'h1111);
      rd0_valid = 1'b1; rd0_addr = 8'd3;
      step();
      rd0_valid = 1'b0;
      step();
      check("rw.dv0_new", {31'd0, rd0_dvalid}, 32'd1);
      check("rw.new",     {16'd0, rd0_dout}, 32'h5555);

      // Read in flight when reset arrives must never return
      rd0_valid = 1'b1; rd0_addr = 8'd3;
      #1;
      check("rr.rdy0", {31'd0, rd0_ready}, 32'd1);
      step();
      rst = 1'b1;
      wr0_valid = 1'b1; wr0_addr = 8'd9;  wr0_data = 16'h9999;
      wr1_valid = 1'b1; wr1_addr = 8'd10; wr1_data = 16'hAAAA;
      rd0_valid = 1'b1; rd0_addr = 8'd7;
      rd1_valid = 1'b1; rd1_addr = 8'd8;
      #1;
      check("rr.rdy_in_rst", {28'd0, wr0_ready, wr1_ready, rd0_ready, rd1_ready}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_all_zero($sformatf("rr.rst%0d", k));
      end
      rst = 1'b0;
      #1;
      check("rr.first_wr", {30'd0, wr0_ready, wr1_ready}, 32'd2);
      check("rr.first_rd", {30'd0, rd0_ready, rd1_ready}, 32'd2);
      step();
      wr0_valid = 1'b0; wr1_valid = 1'b0; rd0_valid = 1'b0; rd1_valid = 1'b0;
      check("rr.wen",  {31'd0, bram_wen}, 32'd1);
      check("rr.wadd", {24'd0, bram_wadd}, 32'd9);
      check("rr.radd", {24'd0, bram_radd}, 32'd7);
      check("rr.dv_none", {30'd0, rd0_dvalid, rd1_dvalid}, 32'd0);
      step();
      check("rr.dv0", {30'd0, rd0_dvalid, rd1_dvalid}, 32'd2);
      check("rr.d0",  {16'd0, rd0_dout}, 32'h00FF);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("rr.quiet%0d", k), {30'd0, rd0_dvalid, rd1_dvalid}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Round-robin arbiter that shares one simple-dual-port inferred BRAM between two writers and two readers.
- Write-port and read-port arbitration are independent.
- Read data is routed back to the requesting reader with a tagged valid strobe.
- Sits between DSP clients (e.g. coefficient loaders, accumulators) and the BRAM wen/wadd/win and ren/radd/wout ports.

Parameters:
- N_ADDR, 256, BRAM depth; address width AW = $clog2(N_ADDR)
- DATA_WIDTH, 16, BRAM word width
- RD_LATENCY, 1, cycles from bram_ren high to valid bram_wout (integer, 1..4)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr0_valid  input  1  writer 0 request
- wr0_ready  output  1  writer 0 granted this cycle
- wr0_addr  input  AW  writer 0 address
- wr0_data  input  DATA_WIDTH  writer 0 data
- wr1_valid, wr1_ready, wr1_addr, wr1_data: as writer 0, for writer 1
- rd0_valid  input  1  reader 0 request
- rd0_ready  output  1  reader 0 granted this cycle
- rd0_addr  input  AW  reader 0 address
- rd0_dout  output  DATA_WIDTH  reader 0 returned data
- rd0_dvalid  output  1  rd0_dout valid, one-cycle pulse per accepted read
- rd1_valid, rd1_ready, rd1_addr, rd1_dout, rd1_dvalid: as reader 0, for reader 1
- bram_wen  output  1  BRAM write enable
- bram_wadd  output  AW  BRAM write address
- bram_win  output  DATA_WIDTH  BRAM write data
- bram_ren  output  1  BRAM read enable
- bram_radd  output  AW  BRAM read address
- bram_wout  input  DATA_WIDTH  BRAM read data

Behaviour:
- Handshake: a transfer occurs on a cycle with valid & ready. Ready is combinational from the valids and the priority pointer; it never depends on its own client's data. Clients hold addr/data stable while valid is high and not ready.
- Grant rule, per port:
  - only one client valid -> that client is granted every cycle (full throughput);
  - both valid -> the client named by the priority pointer wins;
  - after any grant, the pointer moves to the non-granted client;
  - no valid -> pointer unchanged.
- Write path: the accepted request is registered. bram_wen = 1 with bram_wadd/bram_win on the cycle after the handshake (latency 1). bram_wen = 0 when nothing is accepted; bram_wadd/bram_win hold their last values.
- Read path:
  - the accepted request is registered; bram_ren = 1 with bram_radd on the cycle after the handshake;
  - a RD_LATENCY-deep pipeline carries {valid, client id} alongside;
  - rdN_dvalid pulses exactly 1 + RD_LATENCY cycles after the handshake, with rdN_dout = bram_wout on that cycle;
  - the other client's dvalid stays 0;
  - rdN_dout holds its last value between pulses.
- Reads are returned in acceptance order; back-to-back reads give back-to-back dvalid pulses.
- Same-address write and read in the same BRAM cycle: no forwarding is performed. The BRAM is read-first, so the old data is returned. The arbiter does not stall or reorder.
- Reset (rst = 1 at a clock edge):
  - all outputs 0: ready, bram_wen, bram_ren, bram_wadd, bram_radd, bram_win, rdN_dout, rdN_dvalid;
  - both priority pointers -> client 0;
  - read tag pipeline cleared: reads in flight at reset never produce dvalid;
  - ready is held 0 while rst is high.
- Releasing rst: the first handshake is possible on the first cycle rst is low.

Test Plan:
- Reset, then wr0 only: valid with addr 5, data 0x1234 -> wr0_ready = 1 the same cycle; next cycle bram_wen = 1, wadd = 5, win = 0x1234.
- Both writers valid for 4 cycles (wr0 addr 1/data 0xA, wr1 addr 2/data 0xB) -> grants wr0, wr1, wr0, wr1; bram_wadd sequence 1, 2, 1, 2 each one cycle later.
- RD_LATENCY = 1, mem[7] preloaded 0x00FF: rd1 reads addr 7 -> bram_ren at T+1; rd1_dvalid = 1 with rd1_dout = 0x00FF at T+2; rd0_dvalid stays 0.
- Both readers valid continuously for 6 cycles at distinct addresses -> alternating grants starting with rd0; 6 dvalid pulses, each routed to the correct reader with its address's data, in order.
- Same cycle: write addr 3 = 0x5555 over old value 0x1111, and read addr 3 -> read returns 0x1111; a later read of addr 3 returns 0x5555.
- Read accepted, then rst asserted the next cycle -> no rdN_dvalid ever pulses for it; all outputs 0 during reset; pointers back to client 0.
